// File: rtl/elastic_pipe_register.sv
// elastic_pipe_register: DEPTH-stage valid/ready pipeline of WIDTH-bit words.
// Downstream stalls propagate back through a combinational ready chain.
// Empty stages keep filling while the output is stalled, so words compact
// toward the output.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset; clears valids, loads RESET_VALUE
//   in_data    upstream word
//   in_valid   upstream word present
//   in_ready   word accepted this cycle (combinational)
//   out_data   final-stage data
//   out_valid  final-stage valid
//   out_ready  downstream accepts out_data this cycle
//   flush      drop all held words at next edge; data registers hold
//   count      number of valid stages, 0..DEPTH (combinational)
module elastic_pipe_register #(
   parameter int unsigned      WIDTH       = 8,
   parameter int unsigned      DEPTH       = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [WIDTH-1:0]           in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   input  logic                       flush,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] d [DEPTH];
   logic [DEPTH-1:0] v;
   logic [DEPTH-1:0] rdy;

   // A stage can load when it is empty or when the stage ahead can load.
   always_comb begin
      rdy            = '0;
      rdy[DEPTH-1]   = out_ready | ~v[DEPTH-1];
      for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
         rdy[i] = rdy[i+1] | ~v[i];
      end
   end

   assign in_ready  = rdy[0] & ~flush & ~reset;
   assign out_data  = d[DEPTH-1];
   assign out_valid = v[DEPTH-1];

   // Occupancy: popcount of the stage valid bits.
   always_comb begin
      count = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         count = count + CW'(v[i]);
      end
   end

   // Stage registers. Data only moves with a valid source, so a bubble
   // shifting in leaves the old data word in place.
   always_ff @(posedge clk) begin
      if (reset) begin
         v <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            d[i] <= RESET_VALUE;
         end
      end else if (flush) begin
         v <= '0;
      end else begin
         if (rdy[0]) begin
            v[0] <= in_valid;
            if (in_valid) begin
               d[0] <= in_data;
            end
         end
         for (int i = 1; i < int'(DEPTH); i++) begin
            if (rdy[i]) begin
               v[i] <= v[i-1];
               if (v[i-1]) begin
                  d[i] <= d[i-1];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_elastic_pipe_register.sv
// Testbench for elastic_pipe_register (DEPTH=4, WIDTH=8, RESET_VALUE=0x5A).
// Driver issues directed scenarios followed by random traffic; a monitor
// keeps a queue of accepted words with their accept cycle and compares
// every cycle on the falling edge.
module tb_elastic_pipe_register;

   localparam int unsigned W  = 8;
   localparam int unsigned D  = 4;
   localparam int unsigned CW = $clog2(D + 1);
   localparam logic [W-1:0] RV = 8'h5A;

   typedef struct {
      logic [W-1:0] data;
      int unsigned  acc;
   } item_t;

   logic          clk = 1'b0;
   logic          reset;
   logic [W-1:0]  in_data;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  out_data;
   logic          out_valid;
   logic          out_ready;
   logic          flush;
   logic [CW-1:0] count;

   int          n_chk  = 0;
   int          n_fail = 0;
   int unsigned cyc    = 0;
   item_t       q[$];

   elastic_pipe_register #(
      .WIDTH(W), .DEPTH(D), .RESET_VALUE(RV)
   ) dut (
      .clk(clk), .reset(reset),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .flush(flush), .count(count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   // Monitor / scoreboard. The oldest held word reaches the output exactly
   // D cycles after its accept cycle; words behind it never overtake it.
   initial begin : monitor
      logic prev_reset;
      logic exp_ov;
      logic exp_ir;
      prev_reset = 1'b1;
      @(posedge clk);
      forever begin
         @(negedge clk);
         exp_ir = !reset && !flush && (q.size() < D || out_ready);
         exp_ov = (q.size() > 0) ? ((cyc - q[0].acc) >= D) : 1'b0;
         chk("count", 32'(count), 32'(q.size()));
         chk("in_ready", 32'(in_ready), 32'(exp_ir));
         chk("out_valid", 32'(out_valid), 32'(exp_ov));
         if (prev_reset && !reset)
            chk("reset_out_data", 32'(out_data), 32'(RV));
         if (out_valid && q.size() > 0)
            chk("out_data", 32'(out_data), 32'(q[0].data));
         if (reset) begin
            q.delete();
         end else begin
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (flush) q.delete();
            else if (in_valid && in_ready) q.push_back('{data: in_data, acc: cyc});
         end
         prev_reset = reset;
      end
   end

   task automatic step(input logic iv, input logic [W-1:0] id, input logic ordy,
                       input logic fl, input logic rs);
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      flush     = fl;
      reset     = rs;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic ordy, input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, ordy, 1'b0, 1'b0);
   endtask

   initial begin : driver
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

      // Streaming at full rate.
      for (int i = 1; i <= 12; i++) step(1'b1, W'(i), 1'b1, 1'b0, 1'b0);
      idle(1'b1, 6);

      // Fill under stall, then release with a simultaneous accept.
      for (int i = 0; i < 4; i++) step(1'b1, 8'hA0 + W'(i), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 8'hA4, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'hA4, 1'b1, 1'b0, 1'b0);
      step(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
      idle(1'b1, 8);

      // Bubble collapse under stall.
      step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
      idle(1'b0, 2);
      step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
      idle(1'b0, 5);
      idle(1'b1, 4);

      // Flush with a word offered in the same cycle.
      for (int i = 0; i < 3; i++) step(1'b1, 8'h30 + W'(i), 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
      idle(1'b1, 6);

      // Reset over flush and input on a full chain.
      for (int i = 0; i < 4; i++) step(1'b1, 8'h40 + W'(i), 1'b0, 1'b0, 1'b0);
      idle(1'b0, 3);
      step(1'b1, 8'h66, 1'b1, 1'b1, 1'b1);
      idle(1'b1, 2);

      // Full chain with simultaneous pop and push.
      for (int i = 0; i < 4; i++) step(1'b1, 8'h50 + W'(i), 1'b0, 1'b0, 1'b0);
      idle(1'b0, 4);
      step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
      idle(1'b1, 8);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         step(1'($urandom_range(0, 9) < 7), W'($urandom),
              1'($urandom_range(0, 9) < 6),
              1'($urandom_range(0, 99) < 2),
              1'($urandom_range(0, 199) < 2));
      end
      idle(1'b1, 8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
